// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared FSM encodings, default latencies and helpers for md_unit
package md_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    localparam int MULT_LAT_DEF = 4;
    localparam int DIV_ITER_DEF = 32;

    // Magnitude of a 32-bit operand; only negative when interpreted as signed.
    function automatic logic [31:0] md_mag(input logic [31:0] value, input logic is_signed);
        return (is_signed && value[31]) ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/div_core.sv
// rtl/div_core.sv - restoring divider on magnitudes with counter and sign fixup
module div_core
    import md_pkg::*;
#(
    parameter int DIV_ITER = DIV_ITER_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        run,
    input  logic        sign_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        last,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [5:0]  cnt;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [31:0] dvd_q;
    logic        neg_quo;
    logic        neg_rem;

    logic [32:0] shifted;
    logic [33:0] diff;

    // Trial subtraction of the divisor from the partial remainder shifted left by one.
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = {1'b0, shifted} - {2'b00, dvs_q};
    assign last    = run && (cnt == 6'(DIV_ITER));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
        end else if (load) begin
            cnt     <= '0;
            rem_q   <= '0;
            quo_q   <= md_mag(dividend, sign_op);
            dvs_q   <= md_mag(divisor, sign_op);
            dvd_q   <= dividend;
            neg_quo <= sign_op && (dividend[31] ^ divisor[31]);
            neg_rem <= sign_op && dividend[31];
        end else if (run && !last) begin
            cnt <= cnt + 6'd1;
            if (!diff[33]) begin
                rem_q <= diff[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= shifted[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
            end
        end
    end

    // Divide by zero bypasses the sign fixup so the raw dividend comes back as HI.
    always_comb begin
        quotient  = neg_quo ? (~quo_q + 32'd1) : quo_q;
        remainder = neg_rem ? (~rem_q + 32'd1) : rem_q;
        if (dvs_q == 32'd0) begin
            quotient  = 32'hFFFF_FFFF;
            remainder = dvd_q;
        end
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO result registers
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_ITER = DIV_ITER_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic        sign_op,
    input  logic        cancel,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        multbusy,
    output logic        multover,
    output logic        divbusy,
    output logic        divover,
    output logic        mdcs,
    output logic [31:0] mdhidata,
    output logic [31:0] mdlodata
);

    md_state_t   state;
    md_state_t   next_state;

    logic [3:0]  mcnt;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_sign;
    logic        op_is_div;

    logic        take_div;
    logic        take_mult;
    logic        mult_last;
    logic        mult_fin;
    logic        div_fin;
    logic        div_last;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;

    assign take_div  = (state == ST_IDLE) && start_div;
    assign take_mult = (state == ST_IDLE) && start_mult && !start_div;
    assign mult_last = (mcnt == 4'(MULT_LAT - 1));
    assign mult_fin  = (state == ST_MULT) && !cancel && mult_last;
    assign div_fin   = (state == ST_DIV) && !cancel && div_last;

    // Low 64 bits of a 64x64 product are exact for both sign- and zero-extended inputs.
    assign ext_a   = mul_sign ? {{32{mul_a[31]}}, mul_a} : {32'd0, mul_a};
    assign ext_b   = mul_sign ? {{32{mul_b[31]}}, mul_b} : {32'd0, mul_b};
    assign product = ext_a * ext_b;

    div_core #(
        .DIV_ITER (DIV_ITER)
    ) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load      (take_div),
        .run       (state == ST_DIV),
        .sign_op   (sign_op),
        .dividend  (opa),
        .divisor   (opb),
        .last      (div_last),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start_div) begin
                    next_state = ST_DIV;
                end else if (start_mult) begin
                    next_state = ST_MULT;
                end
            end
            ST_MULT: begin
                if (cancel) begin
                    next_state = ST_IDLE;
                end else if (mult_last) begin
                    next_state = ST_DONE;
                end
            end
            ST_DIV: begin
                if (cancel) begin
                    next_state = ST_IDLE;
                end else if (div_last) begin
                    next_state = ST_DONE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        multbusy = 1'b0;
        divbusy  = 1'b0;
        multover = 1'b0;
        divover  = 1'b0;
        case (state)
            ST_MULT: multbusy = 1'b1;
            ST_DIV:  divbusy  = 1'b1;
            ST_DONE: begin
                multover = !op_is_div;
                divover  = op_is_div;
            end
            default: ;
        endcase
        mdcs = multover | divover;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcnt      <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_sign  <= 1'b0;
            op_is_div <= 1'b0;
            mdhidata  <= '0;
            mdlodata  <= '0;
        end else begin
            if (take_div || take_mult) begin
                mul_a     <= opa;
                mul_b     <= opb;
                mul_sign  <= sign_op;
                op_is_div <= take_div;
                mcnt      <= '0;
            end else if ((state == ST_MULT) && !mult_last) begin
                mcnt <= mcnt + 4'd1;
            end
            if (mult_fin) begin
                mdhidata <= product[63:32];
                mdlodata <= product[31:0];
            end else if (div_fin) begin
                mdhidata <= div_rem;
                mdlodata <= div_quo;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed self-checking bench for md_unit
module tb_md_unit;
    import md_pkg::*;

    logic        clk;
    logic        rst;
    logic        start_mult;
    logic        start_div;
    logic        sign_op;
    logic        cancel;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        multbusy;
    logic        multover;
    logic        divbusy;
    logic        divover;
    logic        mdcs;
    logic [31:0] mdhidata;
    logic [31:0] mdlodata;

    int checks   = 0;
    int failures = 0;

    md_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start_mult (start_mult),
        .start_div  (start_div),
        .sign_op    (sign_op),
        .cancel     (cancel),
        .opa        (opa),
        .opb        (opb),
        .multbusy   (multbusy),
        .multover   (multover),
        .divbusy    (divbusy),
        .divover    (divover),
        .mdcs       (mdcs),
        .mdhidata   (mdhidata),
        .mdlodata   (mdlodata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation from IDLE, count busy cycles up to the completion pulse, check results.
    task automatic run_op(input string tag, input bit is_div, input bit sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_busy);
        int busy_n;
        bit seen;
        busy_n = 0;
        seen   = 1'b0;
        opa = a;
        opb = b;
        sign_op = sgn;
        start_div  = is_div;
        start_mult = !is_div;
        step();
        start_div  = 1'b0;
        start_mult = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (is_div ? divover : multover) begin
                seen = 1'b1;
            end else begin
                if (is_div ? divbusy : multbusy) busy_n++;
                step();
            end
        end
        chk($sformatf("%s_done", tag), 64'(seen), 64'd1);
        chk($sformatf("%s_busy", tag), 64'(busy_n), 64'(exp_busy));
        chk($sformatf("%s_mdcs", tag), 64'(mdcs), 64'd1);
        chk($sformatf("%s_hilo", tag), {mdhidata, mdlodata}, {exp_hi, exp_lo});
        step();
        chk($sformatf("%s_idle", tag), 64'({multbusy, divbusy, multover, divover, mdcs}), 64'd0);
    endtask

    initial begin
        bit seen_over;
        bit seen_mult;
        int busy_n;

        rst = 1'b1;
        start_mult = 1'b0;
        start_div = 1'b0;
        sign_op = 1'b0;
        cancel = 1'b0;
        opa = 32'h1234_5678;
        opb = 32'h9ABC_DEF0;
        step();
        step();
        rst = 1'b0;
        chk("reset_flags", 64'({multbusy, multover, divbusy, divover, mdcs}), 64'd0);
        chk("reset_hilo", {mdhidata, mdlodata}, 64'd0);

        run_op("mul_s_m3x5",   1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 4);
        run_op("mul_u_max",    1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 4);
        run_op("mul_s_minsq",  1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 4);
        run_op("mul_u_carry",  1'b0, 1'b0, 32'h8000_0000, 32'd2,        32'h0000_0001, 32'h0000_0000, 4);
        run_op("div_s_m7by2",  1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_op("div_u_100by7", 1'b1, 1'b0, 32'd100,       32'd7,        32'd2,         32'd14,        33);
        run_op("div_u_9by0",   1'b1, 1'b0, 32'd9,         32'd0,        32'd9,         32'hFFFF_FFFF, 33);
        run_op("div_s_m9by0",  1'b1, 1'b1, 32'hFFFF_FFF7, 32'd0,        32'hFFFF_FFF7, 32'hFFFF_FFFF, 33);
        run_op("div_s_ovf",    1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33);
        run_op("div_s_7bym2",  1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33);

        // Divide and multiply requested together: divide wins; a later start_mult mid-divide is dropped.
        opa = 32'd1000;
        opb = 32'd7;
        sign_op = 1'b0;
        start_div = 1'b1;
        start_mult = 1'b1;
        step();
        start_div = 1'b0;
        start_mult = 1'b0;
        busy_n = 0;
        seen_over = 1'b0;
        seen_mult = 1'b0;
        for (int i = 0; i < 100 && !seen_over; i++) begin
            if (multbusy || multover) seen_mult = 1'b1;
            if (divover) begin
                seen_over = 1'b1;
            end else begin
                if (divbusy) busy_n++;
                if (i == 5) begin
                    opa = 32'd3;
                    opb = 32'd3;
                    sign_op = 1'b1;
                    start_mult = 1'b1;
                end
                step();
                start_mult = 1'b0;
            end
        end
        chk("div_ignore_done", 64'(seen_over), 64'd1);
        chk("div_ignore_busy", 64'(busy_n), 64'd33);
        chk("div_ignore_nomul", 64'(seen_mult), 64'd0);
        chk("div_ignore_hilo", {mdhidata, mdlodata}, {32'd6, 32'd142});
        step();

        // Cancel on divide cycle 10.
        opa = 32'd50;
        opb = 32'd3;
        start_div = 1'b1;
        step();
        start_div = 1'b0;
        for (int i = 1; i < 10; i++) step();
        chk("cancel_div_c10_busy", 64'(divbusy), 64'd1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel_div_idle", 64'({divbusy, divover, mdcs}), 64'd0);
        seen_over = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (divover || mdcs) seen_over = 1'b1;
            step();
        end
        chk("cancel_div_nopulse", 64'(seen_over), 64'd0);
        chk("cancel_div_hilo", {mdhidata, mdlodata}, {32'd6, 32'd142});

        // Cancel a multiply on its second busy cycle.
        opa = 32'd11;
        opb = 32'd13;
        start_mult = 1'b1;
        step();
        start_mult = 1'b0;
        step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        seen_over = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (multover || mdcs || multbusy) seen_over = 1'b1;
            step();
        end
        chk("cancel_mul_nopulse", 64'(seen_over), 64'd0);
        chk("cancel_mul_hilo", {mdhidata, mdlodata}, {32'd6, 32'd142});

        run_op("mul_s_m1xm1", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 4);

        // Reset on multiply cycle 2.
        opa = 32'd6;
        opb = 32'd7;
        sign_op = 1'b0;
        start_mult = 1'b1;
        step();
        start_mult = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mul_flags", 64'({multbusy, multover, divbusy, divover, mdcs}), 64'd0);
        chk("rst_mul_hilo", {mdhidata, mdlodata}, 64'd0);
        seen_over = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (multover || mdcs || multbusy) seen_over = 1'b1;
            step();
        end
        chk("rst_mul_nopulse", 64'(seen_over), 64'd0);

        // Reset beats a simultaneous start.
        rst = 1'b1;
        start_div = 1'b1;
        step();
        rst = 1'b0;
        start_div = 1'b0;
        step();
        chk("rst_start_prio", 64'({divbusy, multbusy}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
